uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with one-byte holding register and sticky overflow flag.
// Optional even-parity bit after data[7] when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLKS_PER_BIT = 2610,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overflow
);

  // state  | meaning
  // IDLE   | line high, waiting for a byte
  // START  | driving start bit (0)
  // DATA   | shifting data[0..7] out LSB-first
  // PARITY | driving even parity of the frame byte
  // STOP   | driving STOP_BITS stop bits (1)
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LP_STOP_LAST = 3'(STOP_BITS - 1);

  state_t      r_state, w_state_next;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_hold;
  logic        r_hold_full;
  logic        r_overflow;
  logic        w_bit_end;
  logic        w_frame_end;
  logic        w_start_new;
  logic        w_start_hold;
  logic        w_tx;
  logic [7:0]  w_frame_byte;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_bit_end    = (r_baud == 16'd0);
  assign w_frame_end  = (r_state == STOP) && w_bit_end && (r_bit == LP_STOP_LAST);
  assign w_frame_byte = w_start_hold ? r_hold : data_i;

  always_comb begin
    w_state_next = r_state;
    w_start_new  = 1'b0;
    w_start_hold = 1'b0;
    w_tx         = 1'b1;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_state_next = START;
          w_start_new  = 1'b1;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx = r_parity;
        if (w_bit_end) w_state_next = STOP;
      end
`endif
      STOP: begin
        // a held byte wins; otherwise a same-cycle strobe starts the next frame directly
        if (w_frame_end) begin
          if (r_hold_full) begin
            w_state_next = START;
            w_start_hold = 1'b1;
          end else if (valid_i) begin
            w_state_next = START;
            w_start_new  = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud      <= 16'd0;
      r_bit       <= 3'd0;
      r_shift     <= 8'd0;
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      if (w_start_new || w_start_hold) begin
        r_baud  <= LP_BAUD_LAST;
        r_bit   <= 3'd0;
        r_shift <= w_frame_byte;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^w_frame_byte;
`endif
      end else if (r_state != IDLE) begin
        if (w_bit_end) begin
          r_baud <= w_frame_end ? 16'd0 : LP_BAUD_LAST;
          if (r_state == DATA) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= (r_bit == 3'd7) ? 3'd0 : r_bit + 3'd1;
          end else if (r_state == STOP) begin
            r_bit <= w_frame_end ? 3'd0 : r_bit + 3'd1;
          end else begin
            r_bit <= 3'd0;
          end
        end else begin
          r_baud <= r_baud - 16'd1;
        end
      end

      if (w_start_hold) begin
        r_hold_full <= 1'b0;
      end else if (valid_i && (r_state != IDLE) && !r_hold_full && !w_frame_end) begin
        r_hold      <= data_i;
        r_hold_full <= 1'b1;
      end

      if (valid_i && (r_state != IDLE) && r_hold_full) r_overflow <= 1'b1;
    end
  end

  assign tx       = w_tx;
  assign busy     = (r_state != IDLE) || r_hold_full;
  assign done     = w_frame_end;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame checks, hand sequences for back-to-back/overflow/reset/2-stop,
// and a randomized run compared cycle-by-cycle against a frame-position reference model.
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL     = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FL     = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FLC  = FL * CPB;
  localparam int FLC2 = (FL + 1) * CPB;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       valid  = 1'b0;
  logic       valid2 = 1'b0;
  logic [7:0] data   = 8'd0;
  logic [7:0] data2  = 8'd0;
  logic       tx, busy, done, overflow;
  logic       tx2, busy2, done2, overflow2;
  int         n_checks = 0;
  int         n_pass   = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid),
    .tx(tx), .busy(busy), .done(done), .overflow(overflow));

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .data_i(data2), .valid_i(valid2),
    .tx(tx2), .busy(busy2), .done(done2), .overflow(overflow2));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
  endtask

  // line level of bit k of a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR_EN && k == 9) return ^b;
    return 1'b1;
  endfunction

  // reference model: position inside the current frame plus a one-deep holding slot
  logic       m_armed = 1'b0, m_active = 1'b0, m_hold_full = 1'b0, m_ovf = 1'b0;
  logic [7:0] m_byte = 8'd0, m_hold = 8'd0;
  int         m_pos = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_armed <= 1'b1; m_active <= 1'b0; m_hold_full <= 1'b0; m_ovf <= 1'b0; m_pos <= 0;
    end else if (m_active && m_pos != FLC - 1) begin
      m_pos <= m_pos + 1;
      if (valid) begin
        if (m_hold_full) m_ovf <= 1'b1;
        else begin m_hold <= data; m_hold_full <= 1'b1; end
      end
    end else if (m_active) begin
      m_pos <= 0;
      if (m_hold_full) begin
        m_byte <= m_hold; m_hold_full <= 1'b0;
        if (valid) m_ovf <= 1'b1;
      end else if (valid) m_byte <= data;
      else m_active <= 1'b0;
    end else if (valid) begin
      m_active <= 1'b1; m_byte <= data; m_pos <= 0;
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("model_tx",   tx,       m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1);
      check("model_busy", busy,     m_active || m_hold_full);
      check("model_done", done,     m_active && (m_pos == FLC - 1));
      check("model_ovf",  overflow, m_ovf);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy && !busy2) return;
      @(negedge clk);
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  // called at the negedge of cycle N+1 of a frame carrying b
  task automatic expect_frame(input string nm, input logic [7:0] b);
    for (int c = 1; c <= FLC; c++) begin
      if (c > 1) @(negedge clk);
      check({nm, "_tx"}, tx, frame_bit(b, (c - 1) / CPB));
      check({nm, "_done"}, done, c == FLC);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] wire_seq;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int   k;
    logic eb;
    vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0};
    vecs[1] = '{8'h01, 8'b1000_0000, 1'b1};
    vecs[2] = '{8'h80, 8'b0000_0001, 1'b1};
    vecs[3] = '{8'h0F, 8'b1111_0000, 1'b0};
    vecs[4] = '{8'hC8, 8'b0001_0011, 1'b1};
    vecs[5] = '{8'h07, 8'b1110_0000, 1'b1};
    vecs[6] = '{8'h03, 8'b1100_0000, 1'b0};
    vecs[7] = '{8'h6E, 8'b0111_0110, 1'b1};

    // reset, with a strobe that must be ignored
    @(negedge clk); rst = 1'b1; valid = 1'b1; data = 8'h5A;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_tx2", tx2, 1'b1);
    check("rst_busy2", busy2, 1'b0);
    valid = 1'b0; rst = 1'b0;
    @(negedge clk);

    // table: single frames
    for (int v = 0; v < 8; v++) begin
      wait_idle();
      @(negedge clk); valid = 1'b1; data = vecs[v].data;
      @(negedge clk); valid = 1'b0; data = 8'($urandom);
      for (int c = 1; c <= FLC; c++) begin
        if (c > 1) @(negedge clk);
        k = (c - 1) / CPB;
        if (k == 0) eb = 1'b0;
        else if (k <= 8) eb = vecs[v].wire_seq[8-k];
        else if (PAR_EN && k == 9) eb = vecs[v].par;
        else eb = 1'b1;
        if ((c - 1) % CPB == 0 || (c - 1) % CPB == CPB - 1) check("vec_tx", tx, eb);
        check("vec_done", done, c == FLC);
        check("vec_busy", busy, 1'b1);
      end
      @(negedge clk);
      check("vec_end_done", done, 1'b0);
      check("vec_end_busy", busy, 1'b0);
    end

    // back-to-back through the holding register
    wait_idle();
    @(negedge clk); valid = 1'b1; data = 8'h3C;
    @(negedge clk); data = 8'hC3;
    for (int c = 1; c <= 2 * FLC; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) valid = 1'b0;
      check("b2b_busy", busy, 1'b1);
      check("b2b_tx", tx, (c <= FLC) ? frame_bit(8'h3C, (c - 1) / CPB)
                                     : frame_bit(8'hC3, (c - FLC - 1) / CPB));
      check("b2b_done", done, (c == FLC) || (c == 2 * FLC));
    end
    @(negedge clk);
    check("b2b_end_busy", busy, 1'b0);
    check("b2b_ovf", overflow, 1'b0);

    // three strobes within one frame: third is dropped
    @(negedge clk); valid = 1'b1; data = 8'h11;
    @(negedge clk); valid = 1'b0;
    for (int c = 1; c <= 2 * FLC; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 3) begin valid = 1'b1; data = 8'h22; end
      if (c == 4) valid = 1'b0;
      if (c == 6) begin valid = 1'b1; data = 8'h33; end
      if (c == 7) valid = 1'b0;
      check("ovf_tx", tx, (c <= FLC) ? frame_bit(8'h11, (c - 1) / CPB)
                                     : frame_bit(8'h22, (c - FLC - 1) / CPB));
      if (c == 6) check("ovf_before", overflow, 1'b0);
      if (c == 8) check("ovf_set", overflow, 1'b1);
    end
    @(negedge clk);
    check("ovf_no_third", busy, 1'b0);
    repeat (FLC) @(negedge clk);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_idle_tx", tx, 1'b1);

    // reset during DATA bit 3 of 0xFF, then a clean 0x00
    @(negedge clk); valid = 1'b1; data = 8'hFF;
    @(negedge clk); valid = 1'b0;
    for (int c = 2; c <= 18; c++) @(negedge clk);
    check("abort_pre_tx", tx, 1'b1);
    rst = 1'b1; valid = 1'b1; data = 8'h77;
    @(negedge clk);
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ovf", overflow, 1'b0);
    rst = 1'b0; valid = 1'b0;
    @(negedge clk); valid = 1'b1; data = 8'h00;
    @(negedge clk); valid = 1'b0;
    expect_frame("after_rst", 8'h00);

    // two stop bits on the second instance
    wait_idle();
    @(negedge clk); valid2 = 1'b1; data2 = 8'h55;
    @(negedge clk); valid2 = 1'b0; data2 = 8'hAA;
    for (int c = 1; c <= FLC2; c++) begin
      if (c > 1) @(negedge clk);
      check("stop2_tx", tx2, frame_bit(8'h55, (c - 1) / CPB));
      if (c > FLC2 - 2 * CPB) check("stop2_high", tx2, 1'b1);
      check("stop2_done", done2, c == FLC2);
    end
    @(negedge clk);
    check("stop2_end_busy", busy2, 1'b0);

    // randomized traffic against the model, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 24) == 0);
      data  = 8'($urandom);
      rst   = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk); valid = 1'b0; rst = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
